// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: op codes, access sizes,
// FSM states and small op-decoding helpers.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } lsu_state_e;

  function automatic logic is_load(mem_op_e op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic mem_size_e op_size(mem_op_e op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      OP_LW, OP_SW:         return SZ_W;
      default:              return SZ_B;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane steering: byte enables, replicated store data,
// load extraction with sign/zero extension and misalignment detection.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = DATA_WIDTH / 8,
  parameter int LANE_W     = $clog2(NUM_LANES)
) (
  input  mem_op_e                op,
  input  logic [LANE_W-1:0]      lane,
  input  logic [31:0]            mem_data_i,
  input  logic [DATA_WIDTH-1:0]  ram_rdata_i,
  output logic [NUM_LANES-1:0]   be,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic [31:0]            ld_data,
  output logic                   misaligned
);

  mem_size_e                   size;
  logic [3:0]                  mask4;
  logic [31:0]                 rd_lo;
  logic [NUM_LANES-1:0][7:0]   wdata_lanes;

  assign size = op_size(op);

  // Each byte lane picks the store byte it would hold if the access were
  // repeated across the whole RAM word.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wdata_lanes[l] = (size == SZ_B) ? mem_data_i[7:0]           :
                            (size == SZ_H) ? mem_data_i[8*(l%2) +: 8]  :
                                             mem_data_i[8*(l%4) +: 8];
  end
  assign wdata = wdata_lanes;

  always_comb begin
    mask4 = 4'b0001;
    case (size)
      SZ_H:    mask4 = 4'b0011;
      SZ_W:    mask4 = 4'b1111;
      default: mask4 = 4'b0001;
    endcase
  end

  assign be = NUM_LANES'(mask4) << lane;

  assign misaligned = ((size == SZ_H) && lane[0]) ||
                      ((size == SZ_W) && (lane[1:0] != 2'b00));

  assign rd_lo = 32'(ram_rdata_i >> {lane, 3'b000});

  always_comb begin
    ld_data = rd_lo;
    case (op)
      OP_LB:   ld_data = {{24{rd_lo[7]}}, rd_lo[7:0]};
      OP_LBU:  ld_data = {24'b0, rd_lo[7:0]};
      OP_LH:   ld_data = {{16{rd_lo[15]}}, rd_lo[15:0]};
      OP_LHU:  ld_data = {16'b0, rd_lo[15:0]};
      default: ld_data = rd_lo;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one RAM access at a time over a req/ack
// handshake, stalls upstream while it is outstanding, flags misalignment/timeout.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RADDR_WIDTH    = 5,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      valid_i,
  input  logic [RADDR_WIDTH-1:0]    reg_waddr_i,
  input  logic                      reg_we_i,
  input  logic [31:0]               reg_wdata_i,
  input  logic [3:0]                mem_op_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [31:0]               mem_data_i,
  output logic                      stall_o,
  output logic                      err_o,
  output logic                      ram_req_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
  input  logic                      ram_ack_i,
  output logic [RADDR_WIDTH-1:0]    reg_waddr_o,
  output logic                      reg_we_o,
  output logic [31:0]               reg_wdata_o
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int LANE_W    = $clog2(NUM_LANES);
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 2);
  localparam int TO_LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef struct packed {
    mem_op_e                 op;
    logic [LANE_W-1:0]       lane;
    logic [RADDR_WIDTH-1:0]  waddr;
  } req_t;

  lsu_state_e               state_q, state_d;
  req_t                     req_q;
  logic [CNT_W-1:0]         cnt_q;
  mem_op_e                  op_in, align_op;
  logic [LANE_W-1:0]        lane_in, align_lane;
  logic [NUM_LANES-1:0]     be;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [31:0]              ld_data;
  logic                     misaligned, is_mem, expire, stall_c;

  assign op_in   = mem_op_e'(mem_op_i);
  assign lane_in = mem_addr_i[LANE_W-1:0];
  assign is_mem  = valid_i && (is_load(op_in) || is_store(op_in));
  assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

  // One steering instance: it sees the incoming op while idle (enables,
  // store data, alignment) and the latched op while waiting (load extract).
  assign align_op   = (state_q == ST_REQ) ? req_q.op   : op_in;
  assign align_lane = (state_q == ST_REQ) ? req_q.lane : lane_in;

  mem_lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .op          (align_op),
    .lane        (align_lane),
    .mem_data_i  (mem_data_i),
    .ram_rdata_i (ram_rdata_i),
    .be          (be),
    .wdata       (wdata),
    .ld_data     (ld_data),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: if (is_mem && !misaligned) begin
        state_d = ST_REQ;
        stall_c = 1'b1;
      end
      ST_REQ: begin
        stall_c = !ram_ack_i;
        if (ram_ack_i || expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gated so that every output reads 0 while reset is held.
  assign stall_o   = stall_c && rst_n_i;
  assign ram_req_o = (state_q == ST_REQ);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_q       <= '0;
      cnt_q       <= '0;
      err_o       <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_be_o    <= '0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
    end else begin
      err_o    <= 1'b0;
      reg_we_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          reg_waddr_o <= reg_waddr_i;
          reg_wdata_o <= reg_wdata_i;
          if (!is_mem) begin
            reg_we_o <= reg_we_i && valid_i;
          end else if (misaligned) begin
            err_o <= 1'b1;
          end else begin
            req_q       <= '{op: op_in, lane: lane_in, waddr: reg_waddr_i};
            cnt_q       <= '0;
            ram_we_o    <= is_store(op_in);
            ram_be_o    <= be;
            ram_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
            ram_wdata_o <= wdata;
          end
        end
        ST_REQ: begin
          if (ram_ack_i) begin
            reg_waddr_o <= req_q.waddr;
            reg_we_o    <= is_load(req_q.op);
            if (is_load(req_q.op)) reg_wdata_o <= ld_data;
          end else if (expire) begin
            err_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
